// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: turns one-cycle commands into pipelined address/data phases,
// with HREADY wait states, BUSY insertion for late write data and ERROR abort.
module ahb_burst_master #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_INC = 4,
    parameter int unsigned LEN_W    = 5
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_burst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [1:0]        htrans,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata
);
    localparam int unsigned CntW = (LEN_W > 5) ? LEN_W : 5;

    localparam logic [1:0] TrIdle   = 2'b00;
    localparam logic [1:0] TrBusy   = 2'b01;
    localparam logic [1:0] TrNonseq = 2'b10;
    localparam logic [1:0] TrSeq    = 2'b11;

    typedef enum logic [2:0] {StIdle, StAddr, StBurst, StLast, StDone, StErr} state_e;

    state_e             state_q;
    logic               wr_q;
    logic [2:0]         burst_q;
    logic [ADDR_W-1:0]  next_addr_q;
    logic [CntW-1:0]    remain_q;
    logic [DATA_W-1:0]  wbuf_q;
    logic               dp_q;

    logic [CntW-1:0]    cmd_beats;
    logic [ADDR_W-1:0]  wrap_mask;
    logic [ADDR_W-1:0]  addr_inc;
    logic [ADDR_W-1:0]  step_addr;
    logic               addr_done;
    logic               launch;
    logic [1:0]         launch_tr;

    assign hsize     = 3'b010;
    assign addr_done = htrans[1] & hready;

    always_comb begin
        unique case (cmd_burst)
            3'b000:         cmd_beats = CntW'(1);
            3'b001:         cmd_beats = (cmd_len == '0) ? CntW'(1) : CntW'(cmd_len);
            3'b010, 3'b011: cmd_beats = CntW'(4);
            3'b100, 3'b101: cmd_beats = CntW'(8);
            default:        cmd_beats = CntW'(16);
        endcase
    end

    // Wrapping bursts keep the bits above the wrap boundary; incrementing ones use a full mask.
    always_comb begin
        wrap_mask = '1;
        if (burst_q == 3'b010) wrap_mask = ADDR_W'(4 * ADDR_INC - 1);
        if (burst_q == 3'b100) wrap_mask = ADDR_W'(8 * ADDR_INC - 1);
        if (burst_q == 3'b110) wrap_mask = ADDR_W'(16 * ADDR_INC - 1);
        addr_inc  = next_addr_q + ADDR_W'(ADDR_INC);
        step_addr = (next_addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
    end

    always_comb begin
        launch    = 1'b0;
        launch_tr = TrSeq;
        unique case (state_q)
            StAddr: begin
                launch    = !wr_q || wr_valid;
                launch_tr = TrNonseq;
            end
            StBurst: launch = hready && (remain_q != '0) && (!wr_q || wr_valid);
            default: ;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q     <= StIdle;
            wr_q        <= 1'b0;
            burst_q     <= 3'b000;
            next_addr_q <= '0;
            remain_q    <= '0;
            wbuf_q      <= '0;
            dp_q        <= 1'b0;
            cmd_ready   <= 1'b0;
            wr_ready    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            haddr       <= '0;
            hwrite      <= 1'b0;
            hburst      <= 3'b000;
            htrans      <= TrIdle;
            hwdata      <= '0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wr_ready <= 1'b0;

            if (dp_q && hready) begin
                dp_q <= 1'b0;
                if (!wr_q && !hresp) begin
                    rd_valid <= 1'b1;
                    rd_data  <= hrdata;
                end
            end

            if (launch) begin
                htrans      <= launch_tr;
                haddr       <= next_addr_q;
                next_addr_q <= step_addr;
                remain_q    <= remain_q - CntW'(1);
                if (wr_q) begin
                    wbuf_q   <= wr_data;
                    wr_ready <= 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready   <= 1'b0;
                        wr_q        <= cmd_write;
                        burst_q     <= cmd_burst;
                        next_addr_q <= cmd_addr;
                        remain_q    <= cmd_beats;
                        state_q     <= StAddr;
                    end
                end
                StAddr: begin
                    if (launch) begin
                        hwrite  <= wr_q;
                        hburst  <= burst_q;
                        state_q <= StBurst;
                    end
                end
                StBurst: begin
                    if (dp_q && !hready && hresp) begin
                        htrans  <= TrIdle;
                        state_q <= StErr;
                    end else if (addr_done) begin
                        dp_q <= 1'b1;
                        if (wr_q) hwdata <= wbuf_q;
                        if (remain_q == '0) begin
                            htrans  <= TrIdle;
                            state_q <= StLast;
                        end else if (!launch) begin
                            // Write data late: park on the pending beat's address.
                            htrans <= TrBusy;
                            haddr  <= next_addr_q;
                        end
                    end
                end
                StLast: begin
                    if (dp_q && !hready && hresp) state_q <= StErr;
                    else if (dp_q && hready) state_q <= StDone;
                end
                StDone: begin
                    done    <= 1'b1;
                    state_q <= StIdle;
                end
                StErr: begin
                    if (hready) begin
                        done    <= 1'b1;
                        err     <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: a small AHB slave/producer model drives the bus at
// negedge and records accepted addresses, write data, read beats and completions.
module tb_ahb_burst_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 5;

    logic          hclk = 1'b0;
    logic          hresetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [2:0]    cmd_burst = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          hready = 1'b1;
    logic          hresp = 1'b0;
    logic [DW-1:0] hrdata = '0;

    logic          cmd_ready, wr_ready, rd_valid, done, err, hwrite;
    logic [DW-1:0] rd_data, hwdata;
    logic [AW-1:0] haddr;
    logic [2:0]    hsize, hburst;
    logic [1:0]    htrans;

    logic          u1_cmd_ready, u1_wr_ready, u1_rd_valid, u1_done, u1_err, u1_hwrite;
    logic [DW-1:0] u1_rd_data, u1_hwdata;
    logic [AW-1:0] u1_haddr;
    logic [2:0]    u1_hsize, u1_hburst;
    logic [1:0]    u1_htrans;

    ahb_burst_master #(.ADDR_W(AW), .DATA_W(DW), .ADDR_INC(4), .LEN_W(LW)) u_dut (
        .hclk(hclk), .hresetn(hresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .done(done), .err(err), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .htrans(htrans), .hwdata(hwdata), .hready(hready),
        .hresp(hresp), .hrdata(hrdata)
    );

    // Word-indexed twin, fed identically; only its address sequence is inspected.
    ahb_burst_master #(.ADDR_W(AW), .DATA_W(DW), .ADDR_INC(1), .LEN_W(LW)) u_dut1 (
        .hclk(hclk), .hresetn(hresetn), .cmd_valid(cmd_valid), .cmd_ready(u1_cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(u1_wr_ready),
        .rd_valid(u1_rd_valid), .rd_data(u1_rd_data), .done(u1_done), .err(u1_err),
        .haddr(u1_haddr), .hwrite(u1_hwrite), .hsize(u1_hsize), .hburst(u1_hburst),
        .htrans(u1_htrans), .hwdata(u1_hwdata), .hready(hready), .hresp(hresp),
        .hrdata(hrdata)
    );

    always #5 hclk = ~hclk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] aq[$], a1q[$], wobs[$], rq[$], wsrc[$], expq[$];
    int          acc_n, n_wrr, n_done, n_busy, hold_bad, stall_seen;
    int          stall_beat, stall_left, err_beat, err_ph, gap_beat, gap_left, wr_sent;
    int          dp_beat;
    logic        dp_act = 1'b0, dp_wr, last_err, chk_hold;
    logic [1:0]  err_htrans, p_htrans;
    logic [31:0] busy_addr, p_haddr, p_hwdata;
    logic        p_hready = 1'b1;

    always @(negedge hclk) begin
        if (!hresetn) begin
            dp_act = 1'b0;
            hready = 1'b1;
            hresp  = 1'b0;
        end else begin
            hready = 1'b1;
            hresp  = 1'b0;
            if (dp_act) begin
                hrdata = DW'(dp_beat);
                if (dp_beat == stall_beat && stall_left > 0) begin
                    hready = 1'b0;
                    stall_left--;
                    stall_seen++;
                end
                if (dp_beat == err_beat) begin
                    hresp  = 1'b1;
                    hready = (err_ph != 0);
                    if (err_ph != 0) err_htrans = htrans;
                    err_ph++;
                end
            end
            if (chk_hold && !p_hready &&
                (haddr != p_haddr || htrans != p_htrans || hwdata != p_hwdata)) hold_bad++;
            if (htrans == 2'b01) begin
                n_busy++;
                busy_addr = haddr;
            end
            if (dp_act && hready) begin
                if (dp_wr) wobs.push_back(hwdata);
                dp_act = 1'b0;
            end
            if (htrans[1] && hready) begin
                acc_n++;
                aq.push_back(haddr);
                a1q.push_back(u1_haddr);
                dp_act  = 1'b1;
                dp_beat = acc_n;
                dp_wr   = hwrite;
            end
            if (rd_valid) rq.push_back(rd_data);
            if (wr_ready) n_wrr++;
            if (done) begin
                n_done++;
                last_err = err;
            end
            p_hready = hready;
            p_haddr  = haddr;
            p_htrans = htrans;
            p_hwdata = hwdata;
            if (wr_ready && wsrc.size() > 0) begin
                void'(wsrc.pop_front());
                wr_sent++;
            end
            wr_valid = (wsrc.size() > 0);
            wr_data  = wr_valid ? wsrc[0] : '0;
            if (wr_valid && wr_sent == gap_beat - 1 && gap_left > 0) begin
                wr_valid = 1'b0;
                gap_left--;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_list(input string tag, input logic [31:0] got[$]);
        check_eq({tag, ".len"}, 64'(got.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size(); i++)
            check_eq($sformatf("%s[%0d]", tag, i),
                     (i < got.size()) ? 64'(got[i]) : 64'hDEAD_0000_0000, 64'(expq[i]));
    endtask

    task automatic exp_incr(input logic [31:0] base, input logic [31:0] step, input int n);
        expq.delete();
        for (int i = 0; i < n; i++) expq.push_back(base + step * 32'(i));
    endtask

    task automatic exp4(input logic [31:0] a, b, c, d);
        expq.delete();
        expq.push_back(a); expq.push_back(b); expq.push_back(c); expq.push_back(d);
    endtask

    task automatic clear_mon();
        aq.delete(); a1q.delete(); wobs.delete(); rq.delete(); wsrc.delete();
        acc_n = 0; n_wrr = 0; n_done = 0; n_busy = 0; hold_bad = 0; stall_seen = 0;
        stall_beat = 0; stall_left = 0; err_beat = 0; err_ph = 0; gap_beat = 0;
        gap_left = 0; wr_sent = 0; last_err = 1'b0; chk_hold = 1'b0;
        err_htrans = 2'b11; busy_addr = '0;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] b,
                         input logic [4:0] l);
        int i;
        i = 0;
        while (!cmd_ready && i < 50) begin
            @(negedge hclk); #1;
            i++;
        end
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_burst = b; cmd_len = l;
        @(negedge hclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [2:0] b,
                           input logic [4:0] l, output int lat);
        lat = -1;
        issue(w, a, b, l);
        for (int c = 0; c < 300; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            @(negedge hclk); #1;
        end
        check_eq("done_seen", 64'(lat >= 0), 64'd1);
        repeat (2) @(negedge hclk);
        #1;
    endtask

    int lat;

    initial begin
        clear_mon();
        repeat (3) @(negedge hclk);
        #1;
        check_eq("rst.htrans", 64'(htrans), 64'd0);
        check_eq("rst.cmd_ready", 64'(cmd_ready), 64'd0);
        check_eq("rst.hsize", 64'(hsize), 64'd2);
        hresetn = 1'b1;
        repeat (2) @(negedge hclk);
        #1;
        check_eq("idle.cmd_ready", 64'(cmd_ready), 64'd1);

        // SINGLE write
        clear_mon();
        wsrc.push_back(32'hDEADBEEF);
        run_cmd(1'b1, 32'h10, 3'b000, 5'd0, lat);
        check_eq("single.latency", 64'(lat), 64'd4);
        exp_incr(32'h10, 0, 1);
        check_list("single.addr", aq);
        expq.delete(); expq.push_back(32'hDEADBEEF);
        check_list("single.wdata", wobs);
        check_eq("single.done", 64'(n_done), 64'd1);
        check_eq("single.err", 64'(last_err), 64'd0);
        check_eq("single.wr_ready", 64'(n_wrr), 64'd1);

        // INCR4 read
        clear_mon();
        run_cmd(1'b0, 32'h20, 3'b011, 5'd0, lat);
        check_eq("incr4.latency", 64'(lat), 64'd7);
        exp_incr(32'h20, 4, 4);
        check_list("incr4.addr", aq);
        exp_incr(32'd1, 1, 4);
        check_list("incr4.rdata", rq);
        check_eq("incr4.done", 64'(n_done), 64'd1);

        // WRAP4 write from 0x38
        clear_mon();
        for (int i = 0; i < 4; i++) wsrc.push_back(32'hA0 + 32'(i));
        run_cmd(1'b1, 32'h38, 3'b010, 5'd0, lat);
        exp4(32'h38, 32'h3C, 32'h30, 32'h34);
        check_list("wrap4.addr", aq);
        exp4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        check_list("wrap4.wdata", wobs);

        // WRAP4 read from 5: word-indexed and byte-addressed variants
        clear_mon();
        run_cmd(1'b0, 32'h5, 3'b010, 5'd0, lat);
        exp4(32'h5, 32'h6, 32'h7, 32'h4);
        check_list("wrap4w.addr", a1q);
        exp4(32'h5, 32'h9, 32'hD, 32'h1);
        check_list("wrap4b.addr", aq);

        // INCR8 write with two wait states on beat 3
        clear_mon();
        for (int i = 0; i < 8; i++) wsrc.push_back(32'h1000 + 32'(i));
        stall_beat = 3; stall_left = 2; chk_hold = 1'b1;
        run_cmd(1'b1, 32'h100, 3'b101, 5'd0, lat);
        exp_incr(32'h100, 4, 8);
        check_list("stall.addr", aq);
        exp_incr(32'h1000, 1, 8);
        check_list("stall.wdata", wobs);
        check_eq("stall.seen", 64'(stall_seen), 64'd2);
        check_eq("stall.hold", 64'(hold_bad), 64'd0);
        check_eq("stall.wr_ready", 64'(n_wrr), 64'd8);

        // INCR8 write with beat 5 data late -> BUSY
        clear_mon();
        for (int i = 0; i < 8; i++) wsrc.push_back(32'h2000 + 32'(i));
        gap_beat = 5; gap_left = 3;
        run_cmd(1'b1, 32'h100, 3'b101, 5'd0, lat);
        check_eq("busy.cycles", 64'(n_busy), 64'd3);
        check_eq("busy.addr", 64'(busy_addr), 64'h110);
        check_eq("busy.wr_ready", 64'(n_wrr), 64'd8);
        exp_incr(32'h100, 4, 8);
        check_list("busy.addr_seq", aq);
        exp_incr(32'h2000, 1, 8);
        check_list("busy.wdata", wobs);

        // INCR16 read, ERROR on beat 2
        clear_mon();
        err_beat = 2;
        run_cmd(1'b0, 32'h200, 3'b111, 5'd0, lat);
        expq.delete(); expq.push_back(32'd1);
        check_list("error.rdata", rq);
        check_eq("error.htrans", 64'(err_htrans), 64'd0);
        check_eq("error.done", 64'(n_done), 64'd1);
        check_eq("error.err", 64'(last_err), 64'd1);
        check_eq("error.addrs", 64'(aq.size()), 64'd2);

        // INCR with cmd_len = 0
        clear_mon();
        run_cmd(1'b0, 32'h40, 3'b001, 5'd0, lat);
        exp_incr(32'h40, 4, 1);
        check_list("len0.addr", aq);
        check_eq("len0.reads", 64'(rq.size()), 64'd1);
        check_eq("len0.done", 64'(n_done), 64'd1);

        // Reset in the middle of an INCR8 read
        clear_mon();
        issue(1'b0, 32'h300, 3'b101, 5'd0);
        for (int i = 0; i < 50 && acc_n < 3; i++) begin
            @(negedge hclk); #1;
        end
        check_eq("rst.started", 64'(acc_n >= 3), 64'd1);
        hresetn = 1'b0;
        @(negedge hclk); #1;
        check_eq("rst.ctl", 64'({htrans, hburst, hwrite, hsize, cmd_ready, wr_ready,
                                 rd_valid, done, err}), 64'({2'b00, 3'b000, 1'b0, 3'b010,
                                 5'b00000}));
        check_eq("rst.haddr", 64'(haddr), 64'd0);
        check_eq("rst.hwdata", 64'(hwdata), 64'd0);
        check_eq("rst.rd_data", 64'(rd_data), 64'd0);
        hresetn = 1'b1;
        repeat (10) @(negedge hclk);
        #1;
        check_eq("rst.no_done", 64'(n_done), 64'd0);
        check_eq("rst.cmd_ready", 64'(cmd_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ahb_burst_master.md
Name: ahb_burst_master

Overview:
AHB-Lite bus master that converts single-cycle commands (address, direction, burst type) into AHB address/data-phase sequences. It drives the bus that the ahb_slave memory consumes.
- Handles all eight HBURST encodings, pipelined address/data phases, HREADY wait states, BUSY insertion when write data is late, and ERROR-response abort.
- Sits between a local requester (test sequencer or processor glue) and the AHB interconnect.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
ADDR_INC, 4, address step per beat; power of two (4 = byte-addressed words, 1 = word-indexed slaves)
LEN_W, 5, width of undefined-length INCR beat count

Ports:
hclk  in  1  clock, all logic on rising edge
hresetn  in  1  reset, synchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  start address
cmd_burst  in  3  HBURST encoding for the command
cmd_len  in  LEN_W  beat count for INCR (001) only; 0 treated as 1
wr_valid  in  1  write beat data available
wr_data  in  DATA_W  write beat data
wr_ready  out  1  write beat consumed this cycle
rd_valid  out  1  one-cycle pulse, read beat data valid
rd_data  out  DATA_W  read beat data
done  out  1  one-cycle pulse at end of command
err  out  1  qualifies done; 1 = aborted on ERROR response
haddr  out  ADDR_W  AHB address
hwrite  out  1  AHB direction
hsize  out  3  AHB size, constant 3'b010
hburst  out  3  AHB burst
htrans  out  2  AHB transfer: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11
hwdata  out  DATA_W  AHB write data
hready  in  1  AHB ready
hresp  in  1  AHB response, 1 = ERROR
hrdata  in  DATA_W  AHB read data

Behaviour:
- All outputs are registered.
- Reset values (hresetn low at an edge): htrans=00, haddr=0, hwrite=0, hburst=0, hsize=010, hwdata=0, cmd_ready=0, wr_ready=0, rd_valid=0, rd_data=0, done=0, err=0, state=IDLE. Reset mid-burst abandons the command with no done pulse.
- Beats: SINGLE=1, INCR=cmd_len, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16.
- Address:
  - INCR types: haddr += ADDR_INC per beat, mod 2^ADDR_W.
  - WRAP types: wrap size W = beats*ADDR_INC. Bits above log2(W) are fixed; the low bits increment mod W.
- States:
  - IDLE: cmd_ready=1. On handshake, latch command and enter ADDR; cmd_ready drops the next cycle.
  - ADDR: drive htrans=NONSEQ, haddr, hwrite, hburst.
    - For a write, NONSEQ is issued only when wr_valid=1; otherwise htrans stays IDLE.
    - An address phase completes at an edge with hready=1 and htrans NONSEQ/SEQ.
    - On write completion, wr_ready pulses that cycle and wr_data is registered into hwdata for the following data phase.
  - BURST: next beat uses htrans=SEQ and the next address, overlapped with the previous data phase.
    - Write beat with wr_valid=0: drive htrans=BUSY at the same address; no wr_ready; retry SEQ when wr_valid=1.
    - While hready=0, haddr, htrans and hwdata are held unchanged.
  - LAST: all addresses issued; htrans=IDLE; wait for final data phase hready=1.
  - DONE: pulse done=1, err=0; return to IDLE. cmd_ready is 1 in the cycle after done, so back-to-back commands have one idle bus cycle.
  - ERR: entered when a data phase sees hresp=1 & hready=0 (first ERROR cycle).
    - Drive htrans=IDLE that same next edge and cancel remaining beats.
    - Wait for hready=1 (second ERROR cycle), then pulse done=1 with err=1; return to IDLE.
- Read data: a data phase completing with hready=1, hresp=0 gives rd_valid=1 and rd_data=hrdata on the next cycle. No backpressure on reads.
- Completion order: done pulses no earlier than the cycle after the last rd_valid.
- cmd_* inputs are ignored outside IDLE.

Test Plan:
- SINGLE write: addr 0x10, data 0xDEADBEEF, hready=1 → NONSEQ@0x10 one cycle, hwdata=0xDEADBEEF next cycle, done at cycle 4 after accept, err=0.
- INCR4 read: addr 0x20, slave returns 1,2,3,4 → NONSEQ 0x20, SEQ 0x24/0x28/0x2C; rd_valid x4 with data 1..4; one done.
- WRAP4 write: addr 0x38 → addresses 0x38, 0x3C, 0x30, 0x34. With ADDR_INC=1 and addr 5 → 5, 6, 7, 4.
- Wait states and BUSY:
  - INCR8 write with hready=0 for 2 cycles on beat 3 → haddr and hwdata held.
  - Same burst with wr_valid low for beat 5 → htrans=BUSY until data arrives; 8 wr_ready pulses total.
- ERROR: INCR16 read, slave returns hresp=1 on beat 2 → htrans=IDLE after first error cycle; rd_valid only for beat 1; done=1, err=1.
- Reset and INCR length:
  - hresetn low mid-INCR8 → all outputs at reset values on next edge, no done.
  - INCR with cmd_len=0 → exactly one beat.
